fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the IF/ID register.
// Handles stall/flush hazards and halts when the PC leaves the instruction memory range.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  // 34-bit limit so memories of 2^30 words or more never falsely trip the range check.
  localparam logic [33:0] PcLimit = 34'(IMEM_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        pc_in_range;

  assign pc_in_range = {2'b00, pc_q} < PcLimit;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (flush) begin
      pc_d         = redirect_pc & ~32'h3;
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = StRun;
    end else if (stall || state_q == StHalt) begin
      // Hold everything; a halted fetch only leaves via flush or reset.
    end else if (pc_in_range) begin
      pc_d         = pc_q + 32'd4;
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_instruction;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = StHalt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_pc          = pc_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_instruction = ifid_instr_q;
  assign ifid_valid       = ifid_valid_q;
  assign halted           = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios on three instances plus a randomized run
// against a behavioural fetch model.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [16];

  // Main instance: 16 words (byte range 0..63).
  logic        m_reset = 1'b1, m_stall = 1'b0, m_flush = 1'b0;
  logic [31:0] m_rp = '0, m_pc, m_instr_in, m_ifid_pc, m_ifid_instr;
  logic        m_ifid_valid, m_halted;
  assign m_instr_in = (m_pc < 32'd64) ? mem[m_pc[5:2]] : (32'hBAD0_BAD0 ^ m_pc);

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(16), .NOP_INSTR(Nop)) u_main (
    .clk(clk), .reset(m_reset), .stall(m_stall), .flush(m_flush), .redirect_pc(m_rp),
    .imem_pc(m_pc), .imem_instruction(m_instr_in), .ifid_pc(m_ifid_pc),
    .ifid_instruction(m_ifid_instr), .ifid_valid(m_ifid_valid), .halted(m_halted)
  );

  // Small instance: 4 words, used for the halt scenario.
  logic        s_reset = 1'b1, s_stall = 1'b0, s_flush = 1'b0;
  logic [31:0] s_rp = '0, s_pc, s_instr_in, s_ifid_pc, s_ifid_instr;
  logic        s_ifid_valid, s_halted;
  assign s_instr_in = (s_pc < 32'd16) ? mem[s_pc[3:2]] : 32'hFFFF_FFFF;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4), .NOP_INSTR(Nop)) u_small (
    .clk(clk), .reset(s_reset), .stall(s_stall), .flush(s_flush), .redirect_pc(s_rp),
    .imem_pc(s_pc), .imem_instruction(s_instr_in), .ifid_pc(s_ifid_pc),
    .ifid_instruction(s_ifid_instr), .ifid_valid(s_ifid_valid), .halted(s_halted)
  );

  // Wrap instance: memory covers the whole 32-bit space.
  logic        w_reset = 1'b1;
  logic [31:0] w_pc, w_ifid_pc, w_ifid_instr;
  logic        w_ifid_valid, w_halted;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(32'h4000_0000), .NOP_INSTR(Nop)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0),
    .imem_pc(w_pc), .imem_instruction(32'h1234_5678), .ifid_pc(w_ifid_pc),
    .ifid_instruction(w_ifid_instr), .ifid_valid(w_ifid_valid), .halted(w_halted)
  );

  // Reference model of the main instance, advanced by drive_main.
  logic [31:0] r_pc, r_ifid_pc, r_ifid_instr;
  logic        r_valid, r_halt;

  task automatic drive_main(input logic r, input logic s, input logic f, input logic [31:0] rp);
    @(negedge clk);
    m_reset = r; m_stall = s; m_flush = f; m_rp = rp;
    if (r) begin
      r_pc = 32'h0; r_ifid_pc = 32'h0; r_ifid_instr = Nop; r_valid = 1'b0; r_halt = 1'b0;
    end else if (f) begin
      r_ifid_pc = r_pc; r_ifid_instr = Nop; r_valid = 1'b0; r_halt = 1'b0;
      r_pc = {rp[31:2], 2'b00};
    end else if (s || r_halt) begin
      // nothing moves
    end else if (r_pc < 32'd64) begin
      r_ifid_pc = r_pc; r_ifid_instr = mem[r_pc / 4]; r_valid = 1'b1;
      r_pc = r_pc + 32'd4;
    end else begin
      r_ifid_pc = r_pc; r_ifid_instr = Nop; r_valid = 1'b0; r_halt = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_small(input logic r, input logic s, input logic f, input logic [31:0] rp);
    @(negedge clk);
    s_reset = r; s_stall = s; s_flush = f; s_rp = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive_main(1'b1, 1'b1, 1'b1, 32'h40);
    checks++;
    if ({m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid, m_halted} !==
        {32'h0, 32'h0, Nop, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: pc=%h ifid_pc=%h instr=%h v=%b h=%b, want 0 0 %h 0 0",
               m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid, m_halted, Nop);
    end
  endtask

  task automatic test_sequential;
    drive_main(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive_main(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({m_ifid_pc, m_ifid_instr, m_ifid_valid} !== {32'(i * 4), mem[i], 1'b1}) begin
        errors++;
        $display("FAIL seq[%0d]: got %h %h %b, want %h %h 1", i, m_ifid_pc, m_ifid_instr,
                 m_ifid_valid, i * 4, mem[i]);
      end
    end
    checks++;
    if (m_pc !== 32'd16) begin
      errors++;
      $display("FAIL seq_pc: got %h want 10", m_pc);
    end
  endtask

  task automatic test_stall;
    drive_main(1'b1, 1'b0, 1'b0, 32'h0);
    drive_main(1'b0, 1'b0, 1'b0, 32'h0);
    drive_main(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive_main(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid} !== {32'd8, 32'd4, mem[1], 1'b1}) begin
        errors++;
        $display("FAIL stall[%0d]: got pc=%h ifid=%h %h %b, want 8 4 %h 1", i, m_pc, m_ifid_pc,
                 m_ifid_instr, m_ifid_valid, mem[1]);
      end
    end
    drive_main(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({m_ifid_pc, m_ifid_instr, m_ifid_valid} !== {32'd8, mem[2], 1'b1}) begin
      errors++;
      $display("FAIL stall_release: got %h %h %b, want 8 %h 1", m_ifid_pc, m_ifid_instr,
               m_ifid_valid, mem[2]);
    end
  endtask

  task automatic test_flush_stall;
    // imem_pc is 12 here
    drive_main(1'b0, 1'b1, 1'b1, 32'h0000_002B);
    checks++;
    if ({m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid} !== {32'h28, 32'd12, Nop, 1'b0}) begin
      errors++;
      $display("FAIL flush: got pc=%h ifid=%h %h %b, want 28 c %h 0", m_pc, m_ifid_pc,
               m_ifid_instr, m_ifid_valid, Nop);
    end
    drive_main(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({m_ifid_pc, m_ifid_instr, m_ifid_valid} !== {32'h28, mem[10], 1'b1}) begin
      errors++;
      $display("FAIL flush_target: got %h %h %b, want 28 %h 1", m_ifid_pc, m_ifid_instr,
               m_ifid_valid, mem[10]);
    end
  endtask

  task automatic test_reset_mid_run;
    drive_main(1'b1, 1'b0, 1'b1, 32'h30);
    checks++;
    if ({m_ifid_valid, m_pc, m_halted} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got v=%b pc=%h h=%b, want 0 0 0", m_ifid_valid, m_pc, m_halted);
    end
  endtask

  task automatic test_halt;
    drive_small(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive_small(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({s_ifid_pc, s_ifid_instr, s_ifid_valid, s_halted} !==
          {32'(i * 4), mem[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL halt_run[%0d]: got %h %h %b h=%b", i, s_ifid_pc, s_ifid_instr,
                 s_ifid_valid, s_halted);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_small(1'b0, (i == 1), 1'b0, 32'h0);
      checks++;
      if ({s_pc, s_ifid_pc, s_ifid_instr, s_ifid_valid, s_halted} !==
          {32'd16, 32'd16, Nop, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL halt[%0d]: got pc=%h ifid=%h %h %b h=%b, want 10 10 %h 0 1", i, s_pc,
                 s_ifid_pc, s_ifid_instr, s_ifid_valid, s_halted, Nop);
      end
    end
    drive_small(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if ({s_pc, s_ifid_valid, s_halted} !== {32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_flush: got pc=%h v=%b h=%b, want 0 0 0", s_pc, s_ifid_valid, s_halted);
    end
    drive_small(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({s_ifid_pc, s_ifid_instr, s_ifid_valid} !== {32'h0, mem[0], 1'b1}) begin
      errors++;
      $display("FAIL halt_resume: got %h %h %b, want 0 %h 1", s_ifid_pc, s_ifid_instr,
               s_ifid_valid, mem[0]);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    w_reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({w_pc, w_ifid_pc, w_ifid_instr, w_ifid_valid, w_halted} !==
        {32'h0, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap: got pc=%h ifid=%h %h %b h=%b, want 0 fffffffc 12345678 1 0", w_pc,
               w_ifid_pc, w_ifid_instr, w_ifid_valid, w_halted);
    end
  endtask

  task automatic test_random;
    logic        r, s, f;
    logic [31:0] rp;
    drive_main(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      f  = ($urandom_range(0, 5) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rp = $urandom_range(0, 95);
      drive_main(r, s, f, rp);
      checks++;
      if ({m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid, m_halted} !==
          {r_pc, r_ifid_pc, r_ifid_instr, r_valid, r_halt}) begin
        errors++;
        $display("FAIL random[%0d]: got pc=%h ifid=%h %h %b h=%b, want %h %h %h %b %b", i,
                 m_pc, m_ifid_pc, m_ifid_instr, m_ifid_valid, m_halted, r_pc, r_ifid_pc,
                 r_ifid_instr, r_valid, r_halt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_stall();
    test_flush_stall();
    test_reset_mid_run();
    test_halt();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
